// File: rtl/clock_reset_gen.sv
// Start-up sequencer (reset sync -> hold -> run) and derived core clocks, all flop outputs.
// Optional clean clock stop with freeze_req/freeze_ack when CLK_FREEZE_EN is defined.
module clock_reset_gen #(
  parameter int RST_SYNC_STAGES = 2,
  parameter int HOLD_CYCLES     = 8,
  parameter int PROC_DIV        = 4,
  parameter int CNT_W           = 32
) (
  input  logic             clock,
  input  logic             reset,
`ifdef CLK_FREEZE_EN
  input  logic             freeze_req,
  output logic             freeze_ack,
`endif
  output logic             imem_clock,
  output logic             dmem_clock,
  output logic             processor_clock,
  output logic             regfile_clock,
  output logic             core_reset,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int KW = $clog2(PROC_DIV);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST    = KW'(PROC_DIV - 1);
  localparam logic [KW-1:0] K_HALF    = KW'(PROC_DIV / 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

`ifdef CLK_FREEZE_EN
  typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN, ST_FREEZE} state_t;
`else
  typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN} state_t;
`endif

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [RST_SYNC_STAGES-2:0]   r_sync;
  logic [HW-1:0]                r_hold_cnt;
  logic [HW-1:0]                w_hold_nxt;
  logic [KW-1:0]                r_k;
  logic [KW-1:0]                w_k_nxt;
  logic                         w_sync_done;
  logic                         w_run_nxt;
  logic                         w_active_nxt;
  logic                         r_imem_clk;
  logic                         r_dmem_clk;
  logic                         r_proc_clk;
  logic                         r_rf_clk;
  logic                         r_core_rst;
  logic                         r_running;
  logic [CNT_W-1:0]             r_cycle_cnt;
`ifdef CLK_FREEZE_EN
  logic                         r_freeze_ack;
`endif

  // The RESET->HOLD state flop acts as the last synchronizer stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= 1'b1;
      for (int i = 1; i < RST_SYNC_STAGES - 1; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync_done = r_sync[RST_SYNC_STAGES-2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RESET;
      r_hold_cnt <= '0;
      r_k        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_k        <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_k_nxt     = '0;
    case (r_state)
      ST_RESET: begin
        if (w_sync_done) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (r_k == K_LAST) begin
          w_k_nxt = '0;
`ifdef CLK_FREEZE_EN
          // Only stop at the end of a period so processor_clock is already low.
          if (freeze_req) begin
            w_state_nxt = ST_FREEZE;
          end
`endif
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
`ifdef CLK_FREEZE_EN
      ST_FREEZE: begin
        if (!freeze_req) begin
          w_state_nxt = ST_RUN;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  assign w_run_nxt = (w_state_nxt == ST_RUN);
`ifdef CLK_FREEZE_EN
  assign w_active_nxt = w_run_nxt || (w_state_nxt == ST_FREEZE);
`else
  assign w_active_nxt = w_run_nxt;
`endif

  // Outputs are decoded from the next state/phase so every pin is a plain flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_imem_clk  <= 1'b0;
      r_dmem_clk  <= 1'b0;
      r_proc_clk  <= 1'b0;
      r_rf_clk    <= 1'b0;
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_imem_clk <= w_run_nxt && !w_k_nxt[0];
      r_dmem_clk <= w_run_nxt && w_k_nxt[0];
      r_proc_clk <= w_run_nxt && (w_k_nxt < K_HALF);
      r_rf_clk   <= w_run_nxt && (w_k_nxt < K_HALF);
      r_core_rst <= !w_active_nxt;
      r_running  <= w_run_nxt;
      if (w_run_nxt && (w_k_nxt == '0) && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
    end
  end

`ifdef CLK_FREEZE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_freeze_ack <= 1'b0;
    end else begin
      r_freeze_ack <= (w_state_nxt == ST_FREEZE);
    end
  end

  assign freeze_ack = r_freeze_ack;
`endif

  assign imem_clock      = r_imem_clk;
  assign dmem_clock      = r_dmem_clk;
  assign processor_clock = r_proc_clk;
  assign regfile_clock   = r_rf_clk;
  assign core_reset      = r_core_rst;
  assign running         = r_running;
  assign cycle_count     = r_cycle_cnt;

endmodule
